// File: rtl/stim_txn_gen_if.sv
// stim_txn_gen_if: control and generated-bus signals of the stimulus generator.
// master = generator side, slave = consumer/controller side.
`timescale 1ns/1ps
interface stim_txn_gen_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 8
);
    logic              start;
    logic              abort;
    logic              mode;
    logic [CNT_W-1:0]  num_txn;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              en;
    logic              valid;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  txn_cnt;

    modport master (
        input  start, abort, mode, num_txn,
        output addr, wr, en, valid, busy, done, txn_cnt
    );

    modport slave (
        output start, abort, mode, num_txn,
        input  addr, wr, en, valid, busy, done, txn_cnt
    );
endinterface

// File: rtl/stim_txn_gen.sv
// stim_txn_gen: staggered wr -> en -> addr transaction generator driven by a
// 16-bit Galois LFSR, with optional idle gap between transactions.
// Optional feature macro: STIM_TXN_GEN_INC_MODE_EN adds an incrementing
// address source selected by bus.mode; without it addr is always LFSR-sourced.
`timescale 1ns/1ps
module stim_txn_gen #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned GAP    = 0,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    stim_txn_gen_if.master    bus
);

    localparam int unsigned      LFSR_W   = 16;
    localparam logic [LFSR_W-1:0] TAPS    = 16'hB400;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]        GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_EN,
        S_ADDR,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    logic [LFSR_W-1:0]   lfsr;
    logic [CNT_W-1:0]    num_q;
    logic [CNT_W-1:0]    txn_cnt_q;
    logic [3:0]          gap_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic                en_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic [LFSR_W-1:0]   lfsr_next_c;
    logic                last_c;
    logic [ADDR_W-1:0]   addr_src_c;
    logic                abort_c;

    // One Galois step: shift right, fold taps in when the outgoing bit is 1.
    assign lfsr_next_c = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : {LFSR_W{1'b0}});
    assign last_c      = (txn_cnt_q + CNT_W'(1)) == num_q;
    assign abort_c     = bus.abort && (state != S_IDLE) && (state != S_DONE);

`ifdef STIM_TXN_GEN_INC_MODE_EN
    logic [ADDR_W-1:0] inc_addr;

    assign addr_src_c = bus.mode ? inc_addr : lfsr[ADDR_W-1:0];

    // Incrementing address: cleared per accepted start, steps once per transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_addr <= '0;
        end else if ((state == S_IDLE) && bus.start) begin
            inc_addr <= '0;
        end else if ((state == S_ADDR) && !abort_c) begin
            inc_addr <= inc_addr + ADDR_W'(1);
        end
    end
`else
    logic unused_mode;

    assign unused_mode = bus.mode;
    assign addr_src_c  = lfsr[ADDR_W-1:0];
`endif

    // Sequencer: state, LFSR, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lfsr      <= SEED_EFF;
            num_q     <= '0;
            txn_cnt_q <= '0;
            gap_cnt   <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            en_q      <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (abort_c) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            busy_q <= 1'b1;
                            if (bus.num_txn != '0) begin
                                num_q     <= bus.num_txn;
                                txn_cnt_q <= '0;
                                state     <= S_WR;
                            end else begin
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end
                        end
                    end
                    S_WR: begin
                        wr_q  <= lfsr[ADDR_W];
                        state <= S_EN;
                    end
                    S_EN: begin
                        en_q  <= lfsr[ADDR_W+1];
                        state <= S_ADDR;
                    end
                    S_ADDR: begin
                        addr_q    <= addr_src_c;
                        valid_q   <= 1'b1;
                        txn_cnt_q <= txn_cnt_q + CNT_W'(1);
                        lfsr      <= lfsr_next_c;
                        gap_cnt   <= '0;
                        if (last_c) begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else if (GAP != 0) begin
                            state <= S_GAP;
                        end else begin
                            state <= S_WR;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= S_WR;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    S_DONE: begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.addr    = addr_q;
    assign bus.wr      = wr_q;
    assign bus.en      = en_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_stim_txn_gen.sv
// Directed testbench for stim_txn_gen: GAP=0 instance (dut0) and GAP=2 instance (dut1).
`timescale 1ns/1ps
module tb_stim_txn_gen;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

`ifdef STIM_TXN_GEN_INC_MODE_EN
    localparam bit INC_ON = 1'b1;
`else
    localparam bit INC_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    stim_txn_gen_if #(.ADDR_W(6), .CNT_W(8)) bus0 ();
    stim_txn_gen_if #(.ADDR_W(6), .CNT_W(8)) bus1 ();

    stim_txn_gen #(.ADDR_W(6), .CNT_W(8), .GAP(0), .SEED(16'hACE1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    stim_txn_gen #(.ADDR_W(6), .CNT_W(8), .GAP(2), .SEED(16'hACE1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Bench-side LFSR reference.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out0(input string tag, input logic [5:0] a, input logic w, input logic e,
                            input logic v, input logic b, input logic d, input logic [7:0] c);
        chk({tag, ".addr"},    32'(bus0.addr),    32'(a));
        chk({tag, ".wr"},      32'(bus0.wr),      32'(w));
        chk({tag, ".en"},      32'(bus0.en),      32'(e));
        chk({tag, ".valid"},   32'(bus0.valid),   32'(v));
        chk({tag, ".busy"},    32'(bus0.busy),    32'(b));
        chk({tag, ".done"},    32'(bus0.done),    32'(d));
        chk({tag, ".txn_cnt"}, 32'(bus0.txn_cnt), 32'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] m;
    logic [15:0] m1;
    logic [5:0]  exp_addr;
    logic        exp_wr;
    logic        exp_en;
    logic [7:0]  exp_cnt;
    int          vcount;
    int          last_v;

    // Run k of dut0 through wr, en, addr edges against the model; updates expectations.
    task automatic txn0(input string tag, input int k, input int n, input logic [5:0] a_exp);
        tick();
        exp_wr = m[6];
        chk({tag, ".wr"}, 32'(bus0.wr), 32'(exp_wr));
        chk({tag, ".valid_wr"}, 32'(bus0.valid), 32'd0);
        tick();
        exp_en = m[7];
        chk({tag, ".en"}, 32'(bus0.en), 32'(exp_en));
        tick();
        exp_addr = a_exp;
        exp_cnt  = 8'(k + 1);
        chk({tag, ".addr"},  32'(bus0.addr),    32'(exp_addr));
        chk({tag, ".valid"}, 32'(bus0.valid),   32'd1);
        chk({tag, ".cnt"},   32'(bus0.txn_cnt), 32'(exp_cnt));
        chk({tag, ".done"},  32'(bus0.done),    32'(k == n - 1));
        m = lfsr_step(m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.mode = 1'b0; bus0.num_txn = 8'd0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.mode = 1'b0; bus1.num_txn = 8'd0;
        m = 16'hACE1;
        m1 = 16'hACE1;

        // Reset held for 3 cycles, then released.
        repeat (3) tick();
        chk_out0("rst.hold", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick();
        chk_out0("rst.rel", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("rst.busy1", 32'(bus1.busy), 32'd0);
        chk("rst.addr1", 32'(bus1.addr), 32'd0);

        // Random mode, GAP=0, 4 transactions; first one hand-computed from 16'hACE1.
        bus0.start = 1'b1; bus0.num_txn = 8'd4;
        tick();
        bus0.start = 1'b0; bus0.num_txn = 8'd99;
        chk("rnd.busy", 32'(bus0.busy), 32'd1);
        chk("rnd.valid0", 32'(bus0.valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) bus0.start = 1'b1;
            txn0("rnd", k, 4, m[5:0]);
            bus0.start = 1'b0;
            if (k == 0) begin
                chk("rnd.hand_addr", 32'(bus0.addr), 32'h21);
                chk("rnd.hand_wr",   32'(bus0.wr),   32'd1);
                chk("rnd.hand_en",   32'(bus0.en),   32'd1);
            end
        end
        chk("rnd.busy_done", 32'(bus0.busy), 32'd1);
        tick();
        chk_out0("rnd.end", exp_addr, exp_wr, exp_en, 1'b0, 1'b0, 1'b0, 8'd4);

        // GAP=2 instance: valid every 5 cycles, done after edge 18, busy low after 19.
        bus1.start = 1'b1; bus1.num_txn = 8'd4;
        tick();
        bus1.start = 1'b0;
        vcount = 0;
        last_v = 0;
        for (int e = 1; e <= 21; e++) begin
            tick();
            if (bus1.valid) begin
                chk("gap.addr", 32'(bus1.addr), 32'(m1[5:0]));
                if (vcount == 0) chk("gap.first", 32'(e), 32'd3);
                else             chk("gap.spacing", 32'(e - last_v), 32'd5);
                last_v = e;
                vcount++;
                m1 = lfsr_step(m1);
            end
            chk("gap.done", 32'(bus1.done), 32'(e == 18));
            if (e == 18) chk("gap.busy18", 32'(bus1.busy), 32'd1);
            if (e == 19) chk("gap.busy19", 32'(bus1.busy), 32'd0);
        end
        chk("gap.vcount", 32'(vcount), 32'd4);
        chk("gap.cnt", 32'(bus1.txn_cnt), 32'd4);

        // num_txn = 0: one done pulse, outputs unchanged.
        bus0.start = 1'b1; bus0.num_txn = 8'd0;
        tick();
        bus0.start = 1'b0;
        chk_out0("zero.e0", exp_addr, exp_wr, exp_en, 1'b0, 1'b1, 1'b1, exp_cnt);
        tick();
        chk_out0("zero.e1", exp_addr, exp_wr, exp_en, 1'b0, 1'b0, 1'b0, exp_cnt);

        // mode = 1, 70 transactions: incrementing wraps at 64 when the feature is built in.
        bus0.mode = 1'b1; bus0.start = 1'b1; bus0.num_txn = 8'd70;
        tick();
        bus0.start = 1'b0;
        for (int k = 0; k < 70; k++) begin
            txn0("inc", k, 70, INC_ON ? 6'(k) : m[5:0]);
        end
        tick();
        chk_out0("inc.end", exp_addr, exp_wr, exp_en, 1'b0, 1'b0, 1'b0, 8'd70);
        bus0.mode = 1'b0;

        // Abort at edge 7 of an 8-transaction run, then restart on the next cycle.
        bus0.start = 1'b1; bus0.num_txn = 8'd8;
        tick();
        bus0.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            txn0("abt", k, 8, m[5:0]);
        end
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk_out0("abt.e7", exp_addr, exp_wr, exp_en, 1'b0, 1'b0, 1'b0, 8'd2);
        bus0.start = 1'b1; bus0.num_txn = 8'd1;
        tick();
        bus0.start = 1'b0;
        chk("abt.restart_busy", 32'(bus0.busy), 32'd1);
        chk("abt.restart_cnt", 32'(bus0.txn_cnt), 32'd0);
        txn0("abt.re", 0, 1, m[5:0]);
        tick();
        chk_out0("abt.re_end", exp_addr, exp_wr, exp_en, 1'b0, 1'b0, 1'b0, 8'd1);

        // Asynchronous reset mid-run, then LFSR restarts from the seed.
        bus0.start = 1'b1; bus0.num_txn = 8'd5;
        tick();
        bus0.start = 1'b0;
        repeat (3) tick();
        chk("mid.valid_pre", 32'(bus0.valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out0("mid.rst", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m = 16'hACE1;
        tick();
        bus0.start = 1'b1; bus0.num_txn = 8'd1;
        tick();
        bus0.start = 1'b0;
        txn0("mid.re", 0, 1, 6'h21);
        tick();
        chk("mid.busy_end", 32'(bus0.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
